// File: rtl/sync_xfer_sched.sv
// sync_xfer_sched: round-robin scheduler sharing one multi-bit synchronizer among NREQ requesters
// Ports: clk/rst (sync active-high), en gates new grants, req/data per requester,
//        gnt/done one-hot pulses, d_presync/sel_id hold the granted word and owner, busy = not IDLE.
module sync_xfer_sched #(
   parameter int NREQ   = 4,
   parameter int WIDTH  = 4,
   parameter int STAGES = 2,
   parameter int GAP    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     data,
   output logic [NREQ-1:0]           gnt,
   output logic [NREQ-1:0]           done,
   output logic [WIDTH-1:0]          d_presync,
   output logic [$clog2(NREQ)-1:0]   sel_id,
   output logic                      busy
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(STAGES + GAP + 2);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   logic [1:0]       state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d, sel_q, sel_d, pick;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d;
   logic [WIDTH-1:0] dat_q, dat_d;
   logic             found, grant, hold_end, gap_end;
   // first requester at or after ptr, wrapping modulo NREQ
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
            found = 1'b1;
            pick  = IW'((int'(ptr_q) + i) % NREQ);
         end
      end
   end
   // the shared counter restarts at zero on entry to HOLD and to GAP
   always_comb begin
      grant    = state_q == S_IDLE && en && found;
      hold_end = state_q == S_HOLD && cnt_q == CW'(STAGES);
      gap_end  = state_q == S_GAP && cnt_q == CW'(GAP > 0 ? GAP - 1 : 0);
      state_d  = grant ? S_HOLD : hold_end ? (GAP == 0 ? S_IDLE : S_GAP) : gap_end ? S_IDLE : state_q;
      cnt_d    = (grant || hold_end) ? '0 : cnt_q + CW'(1);
      ptr_d    = grant ? (pick == IW'(NREQ - 1) ? '0 : pick + IW'(1)) : ptr_q;
      sel_d    = grant ? pick : sel_q;
      dat_d    = grant ? data[int'(pick)*WIDTH +: WIDTH] : dat_q;
      gnt_d    = grant ? NREQ'(1) << pick : '0;
      done_d   = hold_end ? NREQ'(1) << sel_q : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         dat_q   <= dat_d;
      end
   end
   assign gnt       = gnt_q;
   assign done      = done_q;
   assign d_presync = dat_q;
   assign sel_id    = sel_q;
   assign busy      = state_q != S_IDLE;
endmodule

// File: tb/tb_sync_xfer_sched.sv
// tb_sync_xfer_sched: two configurations checked against a cycles-since-grant model
module tb_sync_xfer_sched;
   logic        clk, rst, en;
   logic [3:0]  req;
   logic [15:0] data;
   logic [3:0]  gnt_w[2], done_w[2], dp_w[2];
   logic [1:0]  sel_w[2];
   logic        busy_w[2];
   int tests = 0, fails = 0;
   sync_xfer_sched #(.NREQ(4), .WIDTH(4), .STAGES(2), .GAP(1)) u_a (
      .clk(clk), .rst(rst), .en(en), .req(req), .data(data),
      .gnt(gnt_w[0]), .done(done_w[0]), .d_presync(dp_w[0]), .sel_id(sel_w[0]), .busy(busy_w[0]));
   sync_xfer_sched #(.NREQ(4), .WIDTH(4), .STAGES(1), .GAP(0)) u_b (
      .clk(clk), .rst(rst), .en(en), .req(req), .data(data),
      .gnt(gnt_w[1]), .done(done_w[1]), .d_presync(dp_w[1]), .sel_id(sel_w[1]), .busy(busy_w[1]));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask
   function automatic int low_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction
   // model: c counts cycles since the first HOLD cycle; the transfer occupies
   // cycles 0..L-1 (L = STAGES+1+GAP), done shows at cycle STAGES+1
   localparam int BIG = 1000;
   int         mc[2], mptr[2], msel[2];
   logic [3:0] mdat[2];
   bit         m_ok = 0;
   function automatic int stg(input int j); return j == 0 ? 2 : 1; endfunction
   function automatic int gp(input int j);  return j == 0 ? 1 : 0; endfunction
   initial forever begin
      @(negedge clk);
      if (m_ok) begin
         for (int j = 0; j < 2; j++) begin
            int L;
            logic [3:0] oh;
            L  = stg(j) + 1 + gp(j);
            oh = 4'b0001 << msel[j];
            chk($sformatf("gnt%0d", j), gnt_w[j], mc[j] == 0 ? oh : 4'b0);
            chk($sformatf("done%0d", j), done_w[j], mc[j] == stg(j) + 1 ? oh : 4'b0);
            chk($sformatf("busy%0d", j), busy_w[j], mc[j] < L);
            chk($sformatf("dp%0d", j), dp_w[j], mdat[j]);
            chk($sformatf("sel%0d", j), sel_w[j], msel[j]);
            chk($sformatf("gnt_done_excl%0d", j), (|gnt_w[j]) && (|done_w[j]), 0);
            chk($sformatf("onehot%0d", j), $countones(gnt_w[j]) <= 1 && $countones(done_w[j]) <= 1, 1);
         end
      end
      for (int j = 0; j < 2; j++) begin
         if (rst) begin
            mc[j] = BIG; mptr[j] = 0; msel[j] = 0; mdat[j] = 0;
         end else if (mc[j] >= stg(j) + 1 + gp(j) && en && req != 0) begin
            int k;
            k = -1;
            for (int i = 0; i < 4; i++) if (k < 0 && req[(mptr[j] + i) % 4]) k = (mptr[j] + i) % 4;
            mc[j] = 0; msel[j] = k; mdat[j] = data[k*4 +: 4]; mptr[j] = (k + 1) % 4;
         end else if (mc[j] < BIG) mc[j]++;
      end
      if (rst) m_ok = 1;
   end
   task automatic step(); @(posedge clk); #2; endtask
   task automatic do_reset(input logic [3:0] r);
      rst = 1; req = r; step(); step(); rst = 0;
   endtask
   int ca[$], ia[$], cb[$], ib[$];
   task automatic record(input int n);
      ca = {}; ia = {}; cb = {}; ib = {};
      for (int cyc = 1; cyc <= n; cyc++) begin
         step();
         if (gnt_w[0] != 0) begin ca.push_back(cyc); ia.push_back(low_idx(gnt_w[0])); end
         if (gnt_w[1] != 0) begin cb.push_back(cyc); ib.push_back(low_idx(gnt_w[1])); end
      end
   endtask
   initial begin
      int acc;
      rst = 1; en = 1; req = 0; data = 0;
      do_reset(4'b0000);
      // single request
      req = 4'b0100; data = 16'h0A00;
      step(); req = 0;
      chk("s_gnt1", gnt_w[0], 4'b0100);
      chk("s_dp1", dp_w[0], 4'hA);
      chk("s_sel1", sel_w[0], 2);
      chk("s_busy1", busy_w[0], 1);
      step(); step();
      chk("s_dp3", dp_w[0], 4'hA);
      chk("s_b_done3", done_w[1], 4'b0100);
      step();
      chk("s_done4", done_w[0], 4'b0100);
      chk("s_busy4", busy_w[0], 1);
      step();
      chk("s_busy5", busy_w[0], 0);
      chk("s_done5", done_w[0], 4'b0000);
      // round robin, all requesting from reset
      data = 16'h4321;
      do_reset(4'b1111);
      record(22);
      chk("rr_cnt", ca.size(), 5);
      for (int i = 0; i < 5 && i < ca.size(); i++) begin
         chk($sformatf("rr_cyc%0d", i), ca[i], 1 + 5*i);
         chk($sformatf("rr_idx%0d", i), ia[i], i % 4);
      end
      for (int i = 0; i < 4 && i < cb.size(); i++) chk($sformatf("rrb_cyc%0d", i), cb[i], 1 + 3*i);
      // GAP=0 / STAGES=1 alternation
      do_reset(4'b0011);
      record(12);
      chk("alt_cnt", cb.size(), 4);
      for (int i = 0; i < 4 && i < cb.size(); i++) begin
         chk($sformatf("alt_cyc%0d", i), cb[i], 1 + 3*i);
         chk($sformatf("alt_idx%0d", i), ib[i], i % 2);
      end
      // enable gating
      do_reset(4'b0000);
      en = 0; req = 4'b0001;
      acc = 0;
      for (int i = 0; i < 10; i++) begin step(); acc |= gnt_w[0]; end
      chk("en_block", acc, 0);
      en = 1; step();
      chk("en_release", gnt_w[0], 4'b0001);
      req = 0;
      for (int i = 0; i < 6; i++) step();
      // mid-HOLD reset
      do_reset(4'b0000);
      data = 16'h000F; req = 4'b0001;
      step(); req = 0;
      step(); rst = 1;
      step();
      chk("mr_dp", dp_w[0], 4'h0);
      chk("mr_busy", busy_w[0], 0);
      rst = 0; acc = 0;
      for (int i = 0; i < 6; i++) begin step(); acc |= done_w[0]; end
      chk("mr_nodone", acc, 0);
      // withdrawn request while busy
      do_reset(4'b0000);
      req = 4'b0001;
      step(); req = 4'b1000;
      step(); req = 0;
      acc = 0;
      for (int i = 0; i < 12; i++) begin step(); acc |= gnt_w[0] | gnt_w[1]; end
      chk("wd_never", acc, 0);
      // randomized traffic
      do_reset(4'b0000);
      for (int i = 0; i < 3000; i++) begin
         rst  = $urandom_range(0, 199) == 0;
         en   = $urandom_range(0, 7) != 0;
         req  = $urandom_range(0, 2) == 0 ? 4'b0 : 4'($urandom);
         data = 16'($urandom);
         step();
      end
      rst = 0; req = 0;
      step(); step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sync_xfer_sched.md
SYNC_XFER_SCHED -- requirements
Module: sync_xfer_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters sharing one synchronizer channel.
REQ-002 The block SHALL have parameter WIDTH, default 4: data word width, equal to the synchronizer WIDTH.
REQ-003 The block SHALL have parameter STAGES, default 2: synchronizer depth; hold time is STAGES+1 cycles.
REQ-004 The block SHALL have parameter GAP, default 1: number of idle cycles after each hold; 0 is legal.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: when low, no new grant is issued.
REQ-008 The block SHALL have port req, input, NREQ bits: level request per requester.
REQ-009 The block SHALL have port data, input, NREQ*WIDTH bits: requester k owns bits [k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port gnt, output, NREQ bits: one-cycle, one-hot acceptance pulse.
REQ-011 The block SHALL have port done, output, NREQ bits: one-cycle, one-hot pulse when the hold completes.
REQ-012 The block SHALL have port d_presync, output, WIDTH bits: registered word driven to the synchronizer input.
REQ-013 The block SHALL have port sel_id, output, $clog2(NREQ) bits: index of the requester that owns d_presync.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, HOLD and GAP.
REQ-016 In IDLE with en=1 and req!=0, the block SHALL select requester k by round-robin arbitration.
REQ-017 At that clock edge the block SHALL register d_presync<=data[k], sel_id<=k, gnt[k]<=1, hold count<=0 and state<=HOLD.
REQ-018 gnt[k] SHALL therefore be visible in the first HOLD cycle, one cycle after req is sampled.
REQ-019 Round-robin priority SHALL be highest for ptr, then ptr+1 and onward mod NREQ.
REQ-020 ptr SHALL be set to (k+1) mod NREQ on each grant.
REQ-021 HOLD SHALL last exactly STAGES+1 cycles, during which d_presync and sel_id SHALL NOT change.
REQ-022 When HOLD ends, done[sel_id] SHALL pulse for one cycle and the state SHALL become GAP, or IDLE if GAP=0.
REQ-023 GAP SHALL last exactly GAP cycles, after which the state becomes IDLE.
REQ-024 Outside HOLD, d_presync and sel_id SHALL retain their last values.
REQ-025 req SHALL be ignored in HOLD and GAP.
REQ-026 A requester whose req is still high in IDLE after its done pulse SHALL be treated as a new request.
REQ-027 Back-to-back grants with continuous requests SHALL be spaced 1+(STAGES+1)+GAP cycles apart (5 cycles at default parameters).
REQ-028 A req deasserted before being granted SHALL be dropped with no gnt issued.
REQ-029 The arbiter SHALL sample only the current req value in IDLE and SHALL NOT latch past requests.
REQ-030 en=0 SHALL block grants in IDLE only; a transfer in HOLD or GAP SHALL complete normally, including its done pulse.
REQ-031 gnt and done SHALL never be asserted in the same cycle, since the minimum HOLD is 1 cycle.
REQ-032 The block SHALL NOT issue more than one grant per transfer.
REQ-033 gnt SHALL be all-zero in every cycle except the first HOLD cycle.

Reset
REQ-034 While rst=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, gnt=0, done=0, d_presync=0, sel_id=0 and busy=0.
REQ-035 Reset asserted mid-HOLD or mid-GAP SHALL abort the transfer with no done pulse.
REQ-036 The first grant after reset release SHALL be no earlier than the first cycle with rst=0 and req!=0.

Verification
REQ-037 Single request (default parameters): req=4'b0100, data[2]=4'hA in cycle 0 -> gnt=4'b0100 in cycle 1; d_presync=4'hA and sel_id=2 in cycles 1-3; done=4'b0100 in cycle 4; busy high in cycles 1-4, low in cycle 5.
REQ-038 Round robin: req=4'b1111 held continuously from reset -> grants in order 0,1,2,3,0 at cycles 1,6,11,16,21.
REQ-039 Enable gating: en=0 with req=4'b0001 -> no gnt for 10 cycles; en=1 -> gnt[0] in the following cycle.
REQ-040 Mid-transfer reset: rst=1 in cycle 2 of HOLD -> d_presync=0 and busy=0 next cycle; no done pulse.
REQ-041 GAP=0, STAGES=1, continuous req=4'b0011 -> grants alternate 0,1 every 3 cycles; d_presync is stable for the 2 cycles after each gnt.
REQ-042 Withdrawn request: req[3] pulsed for one cycle while busy -> it is never granted; the bench checks the gnt/done ordering and one-hotness every cycle.
